hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS core.
- Generates per-stage enable, freeze and flush controls for the IF/ID, ID/EX and EX/MEM latches and the PC. Each decision comes from load-use, branch/jump, data-memory-wait and halt conditions.
- Tracks stall/flush statistics and a data-memory timeout for the verification harness.
- Sits beside the pipeline latches; its outputs drive their freeze/flush/enable inputs directly.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and latch control outputs of the hazard sequencer.
// The master modport is the datapath; the slave modport is hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   ihit;
    logic                   dhit;
    logic [4:0]             ifid_rs;
    logic [4:0]             ifid_rt;
    logic [4:0]             idex_rt;
    logic                   idex_dREN;
    logic                   exmem_dREN;
    logic                   exmem_dWEN;
    logic                   branch_taken;
    logic                   jump;
    logic                   halt_in;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   ifid_flush;
    logic                   idex_freeze;
    logic                   idex_flush;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   halt_out;
    logic                   mem_timeout;
    logic [STALL_CNT_W-1:0] stall_count;
    logic [STALL_CNT_W-1:0] flush_count;

    modport master (
        output ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dREN,
               exmem_dREN, exmem_dWEN, branch_taken, jump, halt_in,
        input  pc_en, ifid_en, ifid_flush, idex_freeze, idex_flush, idex_en,
               exmem_en, halt_out, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dREN,
               exmem_dREN, exmem_dWEN, branch_taken, jump, halt_in,
        output pc_en, ifid_en, ifid_flush, idex_freeze, idex_flush, idex_en,
               exmem_en, halt_out, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: combinational latch/PC controls from
// RUN/MEMWAIT/HALT state plus hazard inputs, with stall/flush statistics.
module hazard_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input logic        CLK,
    input logic        RST,
    hazard_ctrl_if.slave hif
);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

    state_t                 state;
    logic [7:0]             wcnt;
    logic                   to_q;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [STALL_CNT_W-1:0] flush_cnt;

    logic memop, luse, memstall, to_hit;
    logic pc_en, ifid_en, ifid_flush, idex_freeze, idex_flush, idex_en, exmem_en;

    assign memop    = hif.exmem_dREN | hif.exmem_dWEN;
    assign luse     = hif.idex_dREN & (hif.idex_rt != 5'd0) &
                      ((hif.idex_rt == hif.ifid_rs) | (hif.idex_rt == hif.ifid_rt));
    assign memstall = (state == MEMWAIT) | ((state == RUN) & memop & ~hif.dhit);
    assign to_hit   = (state == MEMWAIT) & ~hif.dhit & (wcnt == WAIT_MAX);

    // A memory stall issues no flush or freeze, so a pending branch or load-use
    // is simply re-evaluated once the pipeline is allowed to move again.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_freeze = 1'b0;
        idex_flush  = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        if (state != HALT && !memstall) begin
            if (hif.branch_taken) begin
                pc_en      = hif.ihit;
                ifid_en    = hif.ihit;
                ifid_flush = hif.ihit;
                idex_flush = hif.ihit;
                idex_en    = hif.ihit;
                exmem_en   = hif.ihit;
            end else if (luse) begin
                idex_freeze = hif.ihit;
                idex_en     = hif.ihit;
                exmem_en    = hif.ihit;
            end else if (hif.jump) begin
                pc_en      = hif.ihit;
                ifid_en    = hif.ihit;
                ifid_flush = hif.ihit;
                idex_en    = hif.ihit;
                exmem_en   = hif.ihit;
            end else begin
                pc_en    = hif.ihit;
                ifid_en  = hif.ihit;
                idex_en  = hif.ihit;
                exmem_en = hif.ihit;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            to_q      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hif.halt_in) begin
                        state <= HALT;
                    end else if (memop && !hif.dhit) begin
                        state <= MEMWAIT;
                        wcnt  <= 8'd0;
                    end
                end
                MEMWAIT: begin
                    if (hif.halt_in) begin
                        state <= HALT;
                    end else if (hif.dhit) begin
                        state <= RUN;
                    end else if (to_hit) begin
                        to_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase

            if (!pc_en && state != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + STALL_CNT_W'(1);
        end
    end

    assign hif.pc_en       = pc_en;
    assign hif.ifid_en     = ifid_en;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.idex_freeze = idex_freeze;
    assign hif.idex_flush  = idex_flush;
    assign hif.idex_en     = idex_en;
    assign hif.exmem_en    = exmem_en;
    assign hif.halt_out    = (state == HALT);
    // Timeout is visible in the very cycle the limit is hit, then held.
    assign hif.mem_timeout = to_q | to_hit;
    assign hif.stall_count = stall_cnt;
    assign hif.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal values
// plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    localparam int CW   = 4;
    localparam int TO   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.STALL_CNT_W(CW)) hif();
    hazard_ctrl #(.STALL_CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .hif(hif)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit m_halted, m_waiting, m_timeout;
    int m_wait, m_stalls, m_flushes;

    // Control vector order: pc_en ifid_en ifid_flush idex_freeze idex_flush idex_en exmem_en
    function automatic logic [6:0] exp_ctl();
        bit memop, luse;
        memop = hif.exmem_dREN || hif.exmem_dWEN;
        luse  = hif.idex_dREN && hif.idex_rt != 0 &&
                (hif.idex_rt == hif.ifid_rs || hif.idex_rt == hif.ifid_rt);
        if (m_halted || m_waiting || (memop && !hif.dhit) || !hif.ihit) return 7'b0000000;
        if (hif.branch_taken) return 7'b1110111;
        if (luse)             return 7'b0001011;
        if (hif.jump)         return 7'b1110011;
        return 7'b1100011;
    endfunction

    function automatic bit exp_timeout();
        return m_timeout || (m_waiting && !hif.dhit && m_wait >= TO);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_halted = 0; m_waiting = 0; m_timeout = 0;
            m_wait = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            logic [6:0] c;
            c = exp_ctl();
            if (!m_halted && !c[6] && m_stalls < CMAX) m_stalls++;
            if (c[4] && m_flushes < CMAX) m_flushes++;
            if (exp_timeout()) m_timeout = 1;
            if (m_halted) begin
            end else if (hif.halt_in) begin
                m_halted = 1; m_waiting = 0;
            end else if (m_waiting) begin
                if (hif.dhit) m_waiting = 0;
                else m_wait++;
            end else if ((hif.exmem_dREN || hif.exmem_dWEN) && !hif.dhit) begin
                m_waiting = 1; m_wait = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("ctl", int'({hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_freeze,
                         hif.idex_flush, hif.idex_en, hif.exmem_en}), int'(exp_ctl()));
        chk("halt_out", int'(hif.halt_out), int'(m_halted));
        chk("mem_timeout", int'(hif.mem_timeout), int'(exp_timeout()));
        chk("stall_count", int'(hif.stall_count), m_stalls);
        chk("flush_count", int'(hif.flush_count), m_flushes);
    endtask

    task automatic tick();
        @(negedge CLK);
        check_model();
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        hif.ihit = 1; hif.dhit = 0; hif.ifid_rs = 0; hif.ifid_rt = 0; hif.idex_rt = 0;
        hif.idex_dREN = 0; hif.exmem_dREN = 0; hif.exmem_dWEN = 0;
        hif.branch_taken = 0; hif.jump = 0; hif.halt_in = 0;
    endtask

    initial begin
        idle();
        repeat (2) adv();
        RST = 0;

        // Fresh reset: counters clear, enables follow ihit
        tick();
        chk("rst_stall", int'(hif.stall_count), 0);
        chk("rst_flush", int'(hif.flush_count), 0);
        chk("rst_halt", int'(hif.halt_out), 0);
        chk("rst_pc_en", int'(hif.pc_en), 1);
        chk("rst_exmem_en", int'(hif.exmem_en), 1);
        adv();

        // Load-use: exactly one bubble, then load has moved on
        hif.idex_dREN = 1; hif.idex_rt = 8; hif.ifid_rs = 8;
        tick();
        chk("lu_pc_en", int'(hif.pc_en), 0);
        chk("lu_ifid_en", int'(hif.ifid_en), 0);
        chk("lu_freeze", int'(hif.idex_freeze), 1);
        adv();
        hif.idex_dREN = 0;
        tick();
        chk("lu_after_pc_en", int'(hif.pc_en), 1);
        chk("lu_after_freeze", int'(hif.idex_freeze), 0);
        adv();
        hif.idex_dREN = 1; hif.idex_rt = 0; hif.ifid_rs = 0;
        tick();
        chk("lu_r0_pc_en", int'(hif.pc_en), 1);
        adv();

        // Branch overrides load-use
        hif.idex_rt = 8; hif.ifid_rt = 8; hif.branch_taken = 1;
        tick();
        chk("br_ifid_flush", int'(hif.ifid_flush), 1);
        chk("br_idex_flush", int'(hif.idex_flush), 1);
        chk("br_freeze", int'(hif.idex_freeze), 0);
        adv();
        idle();
        tick();
        chk("br_flush_count", int'(hif.flush_count), 1);
        chk("br_stall_count", int'(hif.stall_count), 1);
        adv();

        // Data-memory wait: 4 misses then a hit -> 5 stall cycles
        RST = 1; #1; RST = 0;
        hif.exmem_dREN = 1;
        for (int i = 0; i < 5; i++) begin
            hif.dhit = (i == 4);
            tick();
            chk("mw_pc_en", int'(hif.pc_en), 0);
            chk("mw_exmem_en", int'(hif.exmem_en), 0);
            adv();
        end
        idle();
        tick();
        chk("mw_stall_count", int'(hif.stall_count), 5);
        chk("mw_run_pc_en", int'(hif.pc_en), 1);
        adv();

        // Timeout: set during the 4th MEMWAIT cycle, sticky; stall count saturates
        hif.exmem_dWEN = 1;
        tick();
        adv();
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("to_flag", int'(hif.mem_timeout), (i >= 4) ? 1 : 0);
            adv();
        end
        tick();
        chk("to_stall_sat", int'(hif.stall_count), CMAX);
        adv();

        // Reset mid-MEMWAIT clears everything immediately
        idle();
        RST = 1;
        tick();
        chk("rst_mw_stall", int'(hif.stall_count), 0);
        chk("rst_mw_timeout", int'(hif.mem_timeout), 0);
        chk("rst_mw_pc_en", int'(hif.pc_en), 1);
        chk("rst_mw_idex_en", int'(hif.idex_en), 1);
        adv();
        RST = 0;

        // Halt: takes effect next cycle, freezes counters, holds until reset
        hif.halt_in = 1;
        tick();
        chk("h_first_pc_en", int'(hif.pc_en), 1);
        adv();
        hif.halt_in = 0;
        for (int i = 0; i < 6; i++) begin
            hif.exmem_dREN = 1'($urandom_range(0, 1));
            hif.branch_taken = 1'($urandom_range(0, 1));
            tick();
            chk("h_halt_out", int'(hif.halt_out), 1);
            chk("h_pc_en", int'(hif.pc_en), 0);
            chk("h_ifid_flush", int'(hif.ifid_flush), 0);
            chk("h_stall", int'(hif.stall_count), 0);
            adv();
        end
        idle();
        RST = 1;
        tick();
        chk("h_rst_halt", int'(hif.halt_out), 0);
        adv();
        RST = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            hif.ihit         = ($urandom_range(0, 99) < 80);
            hif.dhit         = ($urandom_range(0, 99) < 45);
            hif.ifid_rs      = 5'($urandom_range(0, 3));
            hif.ifid_rt      = 5'($urandom_range(0, 3));
            hif.idex_rt      = 5'($urandom_range(0, 3));
            hif.idex_dREN    = ($urandom_range(0, 99) < 35);
            hif.exmem_dREN   = ($urandom_range(0, 99) < 20);
            hif.exmem_dWEN   = ($urandom_range(0, 99) < 15);
            hif.branch_taken = ($urandom_range(0, 99) < 15);
            hif.jump         = ($urandom_range(0, 99) < 15);
            hif.halt_in      = ($urandom_range(0, 199) == 0);
            RST              = ($urandom_range(0, 59) == 0);
            tick();
            adv();
        end
        RST = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
